// File: rtl/mor1kx_rf_flags_marocchino_if.sv
// Write-back bus from the MAROCCHINO WB mux into the register file / flags sink.
// The WB mux drives the master modport; the RF/flags block takes the slave modport.
interface mor1kx_rf_flags_marocchino_if #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
);
  logic                            wb_rf_wb_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i;
  logic [OPTION_OPERAND_WIDTH-1:0] wb_result_i;
  logic                            wb_flag_set_i;
  logic                            wb_flag_clear_i;
  logic                            wb_atomic_flag_set_i;
  logic                            wb_atomic_flag_clear_i;
  logic                            wb_carry_set_i;
  logic                            wb_carry_clear_i;
  logic                            wb_overflow_set_i;
  logic                            wb_overflow_clear_i;
  logic                            wb_except_any_i;

  modport master (
    output wb_rf_wb_i, wb_rfd_adr_i, wb_result_i,
    output wb_flag_set_i, wb_flag_clear_i,
    output wb_atomic_flag_set_i, wb_atomic_flag_clear_i,
    output wb_carry_set_i, wb_carry_clear_i,
    output wb_overflow_set_i, wb_overflow_clear_i,
    output wb_except_any_i
  );

  modport slave (
    input wb_rf_wb_i, wb_rfd_adr_i, wb_result_i,
    input wb_flag_set_i, wb_flag_clear_i,
    input wb_atomic_flag_set_i, wb_atomic_flag_clear_i,
    input wb_carry_set_i, wb_carry_clear_i,
    input wb_overflow_set_i, wb_overflow_clear_i,
    input wb_except_any_i
  );
endinterface

// File: rtl/mor1kx_rf_flags_marocchino.sv
// MAROCCHINO write-back sink: GPR file with two registered read ports, WB bypass, SR[F/CY/OV].
// Optional MOR1KX_RF_INIT_CLEAR_EN adds a post-reset sweep that clears every register.
module mor1kx_rf_flags_marocchino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  mor1kx_rf_flags_marocchino_if.slave     wb_if,
  input  logic                            pipeline_flush_i,
  input  logic                            padv_dcod_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfa_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfb_adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] rfa_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rfb_o,
  output logic                            sr_flag_o,
  output logic                            sr_carry_o,
  output logic                            sr_overflow_o,
  output logic                            rf_ready_o
);
  localparam int DW    = OPTION_OPERAND_WIDTH;
  localparam int AW    = OPTION_RF_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] ADR_ZERO = {AW{1'b0}};

  logic [DW-1:0] mem_q [0:DEPTH-1];
  logic          mem_we;
  logic [AW-1:0] mem_wadr;
  logic [DW-1:0] mem_wdat;

  logic [DW-1:0] rfa_q, rfa_d, rfb_q, rfb_d;
  logic          flag_q, flag_d, carry_q, carry_d, overflow_q, overflow_d;
  logic          ready_s;

  // Operand as decode should see it: r0 forced to zero, then a same-cycle WB write, then storage.
  function automatic logic [DW-1:0] rd_value(input logic [AW-1:0] adr,
                                             input logic          wb_we,
                                             input logic [AW-1:0] wb_adr,
                                             input logic [DW-1:0] wb_dat,
                                             input logic [DW-1:0] mem_dat);
    logic [DW-1:0] val;
    if (adr == ADR_ZERO) begin
      val = {DW{1'b0}};
    end else if (wb_we && (adr == wb_adr)) begin
      val = wb_dat;
    end else begin
      val = mem_dat;
    end
    return val;
  endfunction

`ifdef MOR1KX_RF_INIT_CLEAR_EN
  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;
  localparam logic [AW-1:0] ADR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] ADR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;

  // Init sweep state, counter and registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= ADR_ZERO;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next state: walk every address once, then park in RUN until the next reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + ADR_ONE;
        if (cnt_q == ADR_LAST) begin
          state_d = RUN;
        end else begin
          state_d = INIT;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
    ready_d = (state_d == RUN);
  end

  assign ready_s = ready_q;

  // Storage write mux: the clearing sweep owns the port until the RF is ready.
  always_comb begin
    mem_we   = 1'b0;
    mem_wadr = wb_if.wb_rfd_adr_i;
    mem_wdat = wb_if.wb_result_i;
    if (state_q == INIT) begin
      mem_we   = 1'b1;
      mem_wadr = cnt_q;
      mem_wdat = {DW{1'b0}};
    end else begin
      mem_we = wb_if.wb_rf_wb_i && (wb_if.wb_rfd_adr_i != ADR_ZERO);
    end
  end
`else
  assign ready_s = 1'b1;

  // Storage write mux: only WB writes, r0 never stored.
  always_comb begin
    mem_wadr = wb_if.wb_rfd_adr_i;
    mem_wdat = wb_if.wb_result_i;
    mem_we   = wb_if.wb_rf_wb_i && (wb_if.wb_rfd_adr_i != ADR_ZERO);
  end
`endif

  // Register storage; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wadr] <= mem_wdat;
    end
  end

  // Read operands: flush wins over decode advance, otherwise hold.
  always_comb begin
    rfa_d = rfa_q;
    rfb_d = rfb_q;
    if (pipeline_flush_i) begin
      rfa_d = {DW{1'b0}};
      rfb_d = {DW{1'b0}};
    end else if (padv_dcod_i) begin
      rfa_d = rd_value(dcod_rfa_adr_i, wb_if.wb_rf_wb_i, wb_if.wb_rfd_adr_i,
                       wb_if.wb_result_i, mem_q[dcod_rfa_adr_i]);
      rfb_d = rd_value(dcod_rfb_adr_i, wb_if.wb_rf_wb_i, wb_if.wb_rfd_adr_i,
                       wb_if.wb_result_i, mem_q[dcod_rfb_adr_i]);
    end else begin
      rfa_d = rfa_q;
      rfb_d = rfb_q;
    end
  end

  // SR flag updates: set beats clear, and an excepting instruction leaves all flags alone.
  always_comb begin
    flag_d     = flag_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    if (!wb_if.wb_except_any_i) begin
      if (wb_if.wb_flag_set_i || wb_if.wb_atomic_flag_set_i) begin
        flag_d = 1'b1;
      end else if (wb_if.wb_flag_clear_i || wb_if.wb_atomic_flag_clear_i) begin
        flag_d = 1'b0;
      end else begin
        flag_d = flag_q;
      end
      if (wb_if.wb_carry_set_i) begin
        carry_d = 1'b1;
      end else if (wb_if.wb_carry_clear_i) begin
        carry_d = 1'b0;
      end else begin
        carry_d = carry_q;
      end
      if (wb_if.wb_overflow_set_i) begin
        overflow_d = 1'b1;
      end else if (wb_if.wb_overflow_clear_i) begin
        overflow_d = 1'b0;
      end else begin
        overflow_d = overflow_q;
      end
    end else begin
      flag_d     = flag_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
    end
  end

  // Operand and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rfa_q      <= {DW{1'b0}};
      rfb_q      <= {DW{1'b0}};
      flag_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rfa_q      <= rfa_d;
      rfb_q      <= rfb_d;
      flag_q     <= flag_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign rfa_o         = rfa_q;
  assign rfb_o         = rfb_q;
  assign sr_flag_o     = flag_q;
  assign sr_carry_o    = carry_q;
  assign sr_overflow_o = overflow_q;
  assign rf_ready_o    = ready_s;
endmodule

// File: tb/tb_mor1kx_rf_flags_marocchino.sv
// Directed self-checking bench for mor1kx_rf_flags_marocchino (default params).
// Init-sweep checks are compiled in only when MOR1KX_RF_INIT_CLEAR_EN is defined.
module tb_mor1kx_rf_flags_marocchino;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipeline_flush_i = 1'b0;
  logic        padv_dcod_i = 1'b0;
  logic [4:0]  dcod_rfa_adr_i = 5'd0;
  logic [4:0]  dcod_rfb_adr_i = 5'd0;
  logic [31:0] rfa_o, rfb_o;
  logic        sr_flag_o, sr_carry_o, sr_overflow_o, rf_ready_o;
  int          n_assert = 0;
  int          n_fail = 0;

  mor1kx_rf_flags_marocchino_if #(.OPTION_OPERAND_WIDTH(32), .OPTION_RF_ADDR_WIDTH(5)) wb_if ();

  mor1kx_rf_flags_marocchino #(.OPTION_OPERAND_WIDTH(32), .OPTION_RF_ADDR_WIDTH(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_if            (wb_if.slave),
    .pipeline_flush_i (pipeline_flush_i),
    .padv_dcod_i      (padv_dcod_i),
    .dcod_rfa_adr_i   (dcod_rfa_adr_i),
    .dcod_rfb_adr_i   (dcod_rfb_adr_i),
    .rfa_o            (rfa_o),
    .rfb_o            (rfb_o),
    .sr_flag_o        (sr_flag_o),
    .sr_carry_o       (sr_carry_o),
    .sr_overflow_o    (sr_overflow_o),
    .rf_ready_o       (rf_ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wb(input logic we, input logic [4:0] adr, input logic [31:0] dat);
    wb_if.wb_rf_wb_i   = we;
    wb_if.wb_rfd_adr_i = adr;
    wb_if.wb_result_i  = dat;
  endtask

  task automatic rd(input logic padv, input logic [4:0] a, input logic [4:0] b);
    padv_dcod_i    = padv;
    dcod_rfa_adr_i = a;
    dcod_rfb_adr_i = b;
  endtask

  task automatic strobes(input logic [7:0] s, input logic exc);
    {wb_if.wb_flag_set_i, wb_if.wb_flag_clear_i,
     wb_if.wb_atomic_flag_set_i, wb_if.wb_atomic_flag_clear_i,
     wb_if.wb_carry_set_i, wb_if.wb_carry_clear_i,
     wb_if.wb_overflow_set_i, wb_if.wb_overflow_clear_i} = s;
    wb_if.wb_except_any_i = exc;
  endtask

  task automatic check_flags(input string tag, input logic f, input logic c, input logic o);
    check({tag, "_f"},  {31'd0, sr_flag_o},     {31'd0, f});
    check({tag, "_cy"}, {31'd0, sr_carry_o},    {31'd0, c});
    check({tag, "_ov"}, {31'd0, sr_overflow_o}, {31'd0, o});
  endtask

  initial begin
    wb(1'b0, 5'd0, 32'd0);
    strobes(8'h00, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_rfa", rfa_o, 32'd0);
    check("rst_rfb", rfb_o, 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
`ifdef MOR1KX_RF_INIT_CLEAR_EN
    check("rst_ready", {31'd0, rf_ready_o}, 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      check("init_ready", {31'd0, rf_ready_o}, (k == 32) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i < 32; i++) begin
      rd(1'b1, i[4:0], 5'(32 - i));
      step();
      check("init_clr_a", rfa_o, 32'd0);
      check("init_clr_b", rfb_o, 32'd0);
    end
`else
    check("rst_ready", {31'd0, rf_ready_o}, 32'd1);
    rst = 1'b0;
    step();
`endif

    // Same-cycle write of r5 seen on both ports through the bypass.
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    rd(1'b1, 5'd5, 5'd5);
    step();
    check("byp_a", rfa_o, 32'hDEADBEEF);
    check("byp_b", rfb_o, 32'hDEADBEEF);
    wb(1'b1, 5'd7, 32'h00001111);
    rd(1'b1, 5'd5, 5'd7);
    step();
    check("mem_r5", rfa_o, 32'hDEADBEEF);
    check("byp_r7", rfb_o, 32'h00001111);
    wb(1'b1, 5'd31, 32'hFFFF0000);
    rd(1'b1, 5'd7, 5'd31);
    step();
    check("mem_r7", rfa_o, 32'h00001111);
    check("byp_r31", rfb_o, 32'hFFFF0000);
    wb(1'b1, 5'd7, 32'h22222222);
    rd(1'b0, 5'd5, 5'd5);
    step();
    check("hold_a", rfa_o, 32'h00001111);
    check("hold_b", rfb_o, 32'hFFFF0000);
    wb(1'b0, 5'd0, 32'd0);
    rd(1'b1, 5'd31, 5'd7);
    step();
    check("mem_r31", rfa_o, 32'hFFFF0000);
    check("mem_r7_new", rfb_o, 32'h22222222);

    // r0 is hard-wired to zero, also against a same-cycle write.
    wb(1'b1, 5'd0, 32'h12345678);
    rd(1'b1, 5'd0, 5'd0);
    step();
    check("r0_byp_a", rfa_o, 32'd0);
    check("r0_byp_b", rfb_o, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    rd(1'b1, 5'd0, 5'd5);
    step();
    check("r0_mem", rfa_o, 32'd0);
    check("r5_again", rfb_o, 32'hDEADBEEF);

    // Flag strobes: {fs,fc,afs,afc,cs,cc,os,oc}.
    rd(1'b0, 5'd0, 5'd0);
    strobes(8'b1100_0000, 1'b0); step(); check_flags("f_setclr", 1'b1, 1'b0, 1'b0);
    strobes(8'b0000_1000, 1'b1); step(); check_flags("cy_exc",   1'b1, 1'b0, 1'b0);
    strobes(8'b0000_0010, 1'b0); step(); check_flags("ov_set",   1'b1, 1'b0, 1'b1);
    strobes(8'b0100_1000, 1'b0); step(); check_flags("f_clr",    1'b0, 1'b1, 1'b1);
    strobes(8'b0010_0000, 1'b0); step(); check_flags("af_set",   1'b1, 1'b1, 1'b1);
    strobes(8'b0001_0101, 1'b1); step(); check_flags("all_exc",  1'b1, 1'b1, 1'b1);
    strobes(8'b0001_0001, 1'b0); step(); check_flags("af_clr",   1'b0, 1'b1, 1'b0);
    strobes(8'b0000_1100, 1'b0); step(); check_flags("cy_both",  1'b0, 1'b1, 1'b0);
    strobes(8'b0000_0100, 1'b0); step(); check_flags("cy_clr",   1'b0, 1'b0, 1'b0);
    strobes(8'b0000_0010, 1'b0); step(); check_flags("ov_set2",  1'b0, 1'b0, 1'b1);
    strobes(8'h00, 1'b0);
    pipeline_flush_i = 1'b1;
    step();
    check_flags("flush_hold", 1'b0, 1'b0, 1'b1);
    pipeline_flush_i = 1'b0;

    // Flush clears held operands and beats decode advance.
    wb(1'b1, 5'd9, 32'hA5A5A5A5);
    rd(1'b1, 5'd9, 5'd5);
    step();
    check("pre_flush_a", rfa_o, 32'hA5A5A5A5);
    check("pre_flush_b", rfb_o, 32'hDEADBEEF);
    wb(1'b0, 5'd0, 32'd0);
    pipeline_flush_i = 1'b1;
    step();
    check("flush_a", rfa_o, 32'd0);
    check("flush_b", rfb_o, 32'd0);
    pipeline_flush_i = 1'b0;
    step();
    check("post_flush_a", rfa_o, 32'hA5A5A5A5);
    rd(1'b0, 5'd9, 5'd9);
    pipeline_flush_i = 1'b1;
    step();
    check("flush_nopadv_a", rfa_o, 32'd0);
    check("flush_nopadv_b", rfb_o, 32'd0);
    pipeline_flush_i = 1'b0;

`ifdef MOR1KX_RF_INIT_CLEAR_EN
    // Reset in the middle of the sweep restarts it from address 0.
    rd(1'b1, 5'd5, 5'd9);
    step();
    check("pre_rst_a", rfa_o, 32'hDEADBEEF);
    rd(1'b0, 5'd0, 5'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_rfa", rfa_o, 32'd0);
    check_flags("rst2", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (10) step();
    check("mid_init_ready", {31'd0, rf_ready_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      check("reinit_ready", {31'd0, rf_ready_o}, (k == 32) ? 32'd1 : 32'd0);
    end
    rd(1'b1, 5'd5, 5'd9);
    step();
    check("reinit_r5", rfa_o, 32'd0);
    check("reinit_r9", rfb_o, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mor1kx_rf_flags_marocchino.md
Name: mor1kx_rf_flags_marocchino

Overview:
- Write-back sink for the MAROCCHINO pipeline: consumes the WB-stage result, destination address, write-request and flag set/clear strobes.
- Holds the general-purpose register file with two registered read ports, WB→decode bypass and hard-wired r0 = 0.
- Holds the architectural SR[F], SR[CY] and SR[OV] bits.
- Sits between the WB mux and the decode/execute operand path.

Parameters:
OPTION_OPERAND_WIDTH, 32, data width of registers and result
OPTION_RF_ADDR_WIDTH, 5, register address width; depth = 2**OPTION_RF_ADDR_WIDTH

Ports:
clk  in  1  clock
rst  in  1  reset (asynchronous, active-high)
pipeline_flush_i  in  1  flush; clears registered read operands
padv_dcod_i  in  1  advance decode; captures read operands
dcod_rfa_adr_i  in  OPTION_RF_ADDR_WIDTH  read port A address
dcod_rfb_adr_i  in  OPTION_RF_ADDR_WIDTH  read port B address
wb_rf_wb_i  in  1  write request from WB
wb_rfd_adr_i  in  OPTION_RF_ADDR_WIDTH  write address
wb_result_i  in  OPTION_OPERAND_WIDTH  write data
wb_flag_set_i, wb_flag_clear_i  in  1 each  SR[F] strobes
wb_atomic_flag_set_i, wb_atomic_flag_clear_i  in  1 each  SR[F] strobes from l.swa
wb_carry_set_i, wb_carry_clear_i  in  1 each  SR[CY] strobes
wb_overflow_set_i, wb_overflow_clear_i  in  1 each  SR[OV] strobes
wb_except_any_i  in  1  WB insn raised an enabled exception
rfa_o  out  OPTION_OPERAND_WIDTH  registered operand A
rfb_o  out  OPTION_OPERAND_WIDTH  registered operand B
sr_flag_o, sr_carry_o, sr_overflow_o  out  1 each  architectural flags
rf_ready_o  out  1  RF usable; ctrl must not advance while low

Behaviour:
Reset values (clk/rst as everywhere in codebase; rst asynchronous, active-high):
- rfa_o = rfb_o = 0.
- sr_flag_o = sr_carry_o = sr_overflow_o = 0.
- rf_ready_o = 0 if MOR1KX_RF_INIT_CLEAR_EN is defined, else 1.

Write port:
- Each posedge with wb_rf_wb_i=1, rf_ready_o=1 and wb_rfd_adr_i≠0: mem[wb_rfd_adr_i] <= wb_result_i.
- Writes to r0 are discarded. Writes while rf_ready_o=0 are discarded.

Read ports (1-cycle latency):
- On posedge with padv_dcod_i=1 and pipeline_flush_i=0, rfa_o <= value(dcod_rfa_adr_i); rfb_o likewise.
- value(adr) = 0 if adr==0; else wb_result_i if wb_rf_wb_i & (adr==wb_rfd_adr_i); else mem[adr].
- The bypass makes a same-cycle write visible; A and B may bypass simultaneously.
- pipeline_flush_i=1 (any padv): rfa_o, rfb_o <= 0. Flush has priority over padv_dcod_i.
- padv_dcod_i=0: rfa_o, rfb_o hold.

Flags (applied every posedge, independent of padv/flush):
- Gated off entirely when wb_except_any_i=1.
- F: set if wb_flag_set_i|wb_atomic_flag_set_i; else clear if wb_flag_clear_i|wb_atomic_flag_clear_i; else hold. Set wins over simultaneous clear.
- CY and OV: same set-over-clear rule with their own strobes.

Init FSM (feature enabled only):
- States INIT, RUN. Reset → INIT, counter = 0.
- INIT: mem[counter] <= 0; counter increments each cycle; at counter == depth-1 go to RUN next cycle.
- RUN: rf_ready_o=1; terminal state until reset.
- rst asserted mid-INIT or in RUN restarts INIT from 0.
- Read-port captures during INIT still follow the read rules; ctrl is required not to issue them.

Optional Feature:
MOR1KX_RF_INIT_CLEAR_EN
- Defined: Init FSM above. rf_ready_o rises exactly 2**OPTION_RF_ADDR_WIDTH cycles after rst deasserts. All entries read 0 afterwards.
- Undefined: no FSM or counter; rf_ready_o tied 1. Storage contents after reset are undefined except r0, which reads 0.

Test Plan:
1. Feature on, default params, release rst → rf_ready_o=0 for 32 cycles then 1; read r1..r31 via padv_dcod_i → rfa_o=0 each.
2. Write r5=0xDEADBEEF; same cycle dcod_rfa_adr_i=5, dcod_rfb_adr_i=5, padv_dcod_i=1 → next cycle rfa_o=rfb_o=0xDEADBEEF (bypass); later read r5 → 0xDEADBEEF.
3. Write r0=0x12345678 with a simultaneous r0 read, then a read r0 → rfa_o=0 both times.
4. wb_flag_set_i=1 and wb_flag_clear_i=1 together → sr_flag_o=1; then wb_carry_set_i=1 with wb_except_any_i=1 → sr_carry_o stays 0.
5. rfa_o=0xA5A5A5A5 held; pipeline_flush_i=1 with padv_dcod_i=1 → rfa_o=rfb_o=0 next cycle.
6. Assert rst at init counter=10 → counter restarts, rf_ready_o stays 0 for a full 32 cycles after release.
